adder_accum_four: RTL and testbench



---
 rtl/adder_accum_four.sv | 69 ++++++
 tb/tb_adder_accum_four.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_accum_four.sv
`timescale 1ns/1ps
// adder_accum_four: folds COUNT 4-bit operands into a 4-bit sum plus saturating carry count.
// Optional macro ACCUM_CIN_EN adds an in_cin port used as the adder carry-in.
module adder_accum_four #(
    parameter int COUNT = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
`ifdef ACCUM_CIN_EN
    input  logic             in_cin,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_sum,
    output logic [CNT_W-1:0] out_carries,
    output logic             out_ovf
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [3:0] LAST = 4'(COUNT - 1);
    state_t state, state_nx;
    logic [3:0] acc, beat;
    logic [CNT_W-1:0] carries;
    logic ovf, cin, take, last;
    logic [4:0] add;
`ifdef ACCUM_CIN_EN
    assign cin = in_cin;
`else
    assign cin = 1'b0;
`endif
    assign take = in_valid && in_ready;
    assign last = beat == LAST;
    assign add = {1'b0, acc} + {1'b0, in_data} + {4'b0, cin};
    assign out_sum = acc;
    assign out_carries = carries;
    assign out_ovf = ovf;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        in_ready = state != HOLD;
        out_valid = state == HOLD;
        if (state == HOLD) state_nx = out_ready ? IDLE : HOLD;
        else if (take) state_nx = last ? HOLD : ACCUM;
    end
    // acc doubles as the result register: it holds the burst total throughout HOLD
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            acc <= '0;
            beat <= '0;
            carries <= '0;
            ovf <= 1'b0;
        end else if (state == HOLD && out_ready) begin
            acc <= '0;
            beat <= '0;
            carries <= '0;
            ovf <= 1'b0;
        end else if (take) begin
            acc <= add[3:0];
            beat <= beat + 4'd1;
            carries <= (add[4] && carries != MAX) ? carries + 1'b1 : carries;
            ovf <= ovf | (add[4] && carries == MAX);
        end
endmodule

// File: tb/tb_adder_accum_four.sv
`timescale 1ns/1ps
// tb_adder_accum_four: scoreboard bench over three COUNT/CNT_W builds of adder_accum_four.
module tb_adder_accum_four;
    typedef struct {int s; int c; int o;} exp_t;
    logic clk = 0;
    logic rst_n = 0;
    logic iv[3];
    logic [3:0] id[3];
    logic ic[3];
    logic ordy[3];
    int mode[3];
    int tot[3];
    int n[3];
    exp_t q[3][$];
    int checks = 0;
    int fails = 0;
    wire ir0, ov0, ovf0, ir1, ov1, ovf1, ir2, ov2, ovf2;
    wire [3:0] os0, os1, os2;
    wire [2:0] oc0;
    wire [1:0] oc1;
    wire [0:0] oc2;

    always #5 clk = ~clk;

    adder_accum_four #(.COUNT(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0), .in_data(id[0]),
`ifdef ACCUM_CIN_EN
        .in_cin(ic[0]),
`endif
        .out_valid(ov0), .out_ready(ordy[0]), .out_sum(os0), .out_carries(oc0), .out_ovf(ovf0));
    adder_accum_four #(.COUNT(6), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1), .in_data(id[1]),
`ifdef ACCUM_CIN_EN
        .in_cin(ic[1]),
`endif
        .out_valid(ov1), .out_ready(ordy[1]), .out_sum(os1), .out_carries(oc1), .out_ovf(ovf1));
    adder_accum_four #(.COUNT(1), .CNT_W(1)) dut_one (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2), .in_data(id[2]),
`ifdef ACCUM_CIN_EN
        .in_cin(ic[2]),
`endif
        .out_valid(ov2), .out_ready(ordy[2]), .out_sum(os2), .out_carries(oc2), .out_ovf(ovf2));

    function automatic int cnt(input int k);
        return k == 0 ? 4 : k == 1 ? 6 : 1;
    endfunction
    function automatic int mx(input int k);
        return k == 0 ? 7 : k == 1 ? 3 : 1;
    endfunction
    function automatic logic ir_of(input int k);
        return k == 0 ? ir0 : k == 1 ? ir1 : ir2;
    endfunction
    function automatic logic ov_of(input int k);
        return k == 0 ? ov0 : k == 1 ? ov1 : ov2;
    endfunction
    function automatic logic [3:0] sum_of(input int k);
        return k == 0 ? os0 : k == 1 ? os1 : os2;
    endfunction
    function automatic logic [3:0] car_of(input int k);
        return k == 0 ? {1'b0, oc0} : k == 1 ? {2'b0, oc1} : {3'b0, oc2};
    endfunction
    function automatic logic ovf_of(input int k);
        return k == 0 ? ovf0 : k == 1 ? ovf1 : ovf2;
    endfunction

    task automatic cmp(input string nm, input int k, input logic [31:0] got, input int expv);
        checks++;
        if (got !== 32'(expv)) begin
            fails++;
            $display("FAIL %s[dut%0d] at %0t: got %0d, expected %0d", nm, k, $time, got, expv);
        end
    endtask

    // Reference: each add carries out at most once, so the exact carry count is total/16
    task automatic model(input int k, input int d, input int c);
        exp_t e;
        tot[k] += d + c;
        n[k]++;
        if (n[k] == cnt(k)) begin
            e.s = tot[k] % 16;
            e.c = tot[k] / 16 > mx(k) ? mx(k) : tot[k] / 16;
            e.o = int'(tot[k] / 16 > mx(k));
            q[k].push_back(e);
            tot[k] = 0;
            n[k] = 0;
        end
    endtask

    task automatic chk(input int k);
        bit have;
        have = q[k].size() > 0;
        cmp("in_ready", k, ir_of(k), int'(!have));
        cmp("out_valid", k, ov_of(k), int'(have));
        if (have) begin
            cmp("out_sum", k, sum_of(k), q[k][0].s);
            cmp("out_carries", k, car_of(k), q[k][0].c);
            cmp("out_ovf", k, ovf_of(k), q[k][0].o);
            if (ov_of(k) && ordy[k]) void'(q[k].pop_front());
        end
    endtask

    always @(negedge clk) begin
        chk(0);
        chk(1);
        chk(2);
    end

    initial forever begin
        @(posedge clk);
        #1;
        foreach (ordy[k]) ordy[k] = mode[k] == 0 ? 1'($urandom_range(0, 1)) : mode[k] == 2;
    end

    task automatic send(input int k, input logic [3:0] d, input logic c);
        bit got;
        got = 0;
        iv[k] = 1;
        id[k] = d;
        ic[k] = c;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            got = ir_of(k);
            @(posedge clk);
            #1;
        end
        iv[k] = 0;
        checks++;
        if (!got) begin
            fails++;
            $display("FAIL accept_timeout[dut%0d]: operand %0d never accepted", k, d);
        end else begin
`ifdef ACCUM_CIN_EN
            model(k, int'(d), int'(c));
`else
            model(k, int'(d), 0);
`endif
        end
    endtask

    task automatic idle(input int k, input int cyc);
        iv[k] = 0;
        id[k] = 4'($urandom);
        repeat (cyc) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic dir(input int k, input int v, input int c, input logic cin, input int es, input int ec, input int eo);
        for (int i = 0; i < c; i++) send(k, 4'(v), cin);
        @(negedge clk);
        cmp("dir_valid", k, ov_of(k), 1);
        cmp("dir_sum", k, sum_of(k), es);
        cmp("dir_carries", k, car_of(k), ec);
        cmp("dir_ovf", k, ovf_of(k), eo);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        foreach (iv[k]) begin
            q[k].delete();
            tot[k] = 0;
            n[k] = 0;
            iv[k] = 0;
        end
        @(negedge clk);
        cmp("rst_in_ready", 0, ir0, 1);
        cmp("rst_out_valid", 0, ov0, 0);
        cmp("rst_out_sum", 0, os0, 0);
        cmp("rst_out_carries", 0, oc0, 0);
        cmp("rst_out_ovf", 0, ovf0, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit busy;
        foreach (iv[k]) begin
            iv[k] = 0;
            id[k] = 0;
            ic[k] = 0;
            ordy[k] = 1;
            mode[k] = 2;
            tot[k] = 0;
            n[k] = 0;
        end
        @(posedge clk);
        #1;
        do_reset();
        for (int i = 1; i <= 4; i++) send(0, 4'(i), 0);
        @(negedge clk);
        cmp("seq_sum", 0, os0, 10);
        cmp("seq_carries", 0, oc0, 0);
        @(posedge clk);
        #1;
        idle(0, 2);
        dir(0, 15, 4, 0, 12, 3, 0);
        idle(0, 2);
        mode[0] = 1;
        dir(0, 3, 4, 0, 12, 0, 0);
        iv[0] = 1;
        repeat (5) begin
            id[0] = 4'($urandom);
            @(posedge clk);
            #1;
        end
        mode[0] = 2;
        dir(0, 2, 4, 0, 8, 0, 0);
        idle(0, 2);
        dir(1, 15, 6, 0, 10, 3, 1);
        idle(1, 2);
        dir(2, 9, 1, 0, 9, 0, 0);
        dir(2, 6, 1, 0, 6, 0, 0);
        idle(2, 2);
        send(0, 7, 0);
        send(0, 7, 0);
        do_reset();
        dir(0, 1, 4, 0, 4, 0, 0);
        idle(0, 2);
        mode[0] = 1;
        for (int i = 0; i < 4; i++) send(0, 5, 0);
        idle(0, 2);
        do_reset();
        mode[0] = 2;
        idle(0, 3);
`ifdef ACCUM_CIN_EN
        dir(0, 5, 4, 1, 8, 1, 0);
        idle(0, 2);
        dir(2, 15, 1, 1, 0, 1, 0);
        idle(2, 2);
`endif
        foreach (mode[k]) mode[k] = 0;
        for (int i = 0; i < 200; i++) begin
            int k;
            k = int'($urandom_range(0, 2));
            send(k, 4'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle(k, int'($urandom_range(1, 3)));
        end
        foreach (mode[k]) mode[k] = 2;
        busy = 1;
        for (int t = 0; t < 100 && busy; t++) begin
            @(posedge clk);
            busy = q[0].size() + q[1].size() + q[2].size() > 0;
        end
        checks++;
        if (busy) begin
            fails++;
            $display("FAIL drain: %0d results still expected, 0 required", q[0].size() + q[1].size() + q[2].size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
